// File: rtl/nios_ocimem_pkg.sv
// Shared types for the OCI RAM arbiter: FSM states, JTAG op encoding, jdo field positions.
package nios_ocimem_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AV_WR,
        ST_AV_RD1,
        ST_AV_RD2,
        ST_JT_WR,
        ST_JT_RD1,
        ST_JT_RD2
    } state_e;

    typedef enum logic {
        JOP_WR = 1'b0,
        JOP_RD = 1'b1
    } jop_e;

    localparam int JDO_W        = 38;
    localparam int JDO_ADDR_LSB = 18;
    localparam int JDO_DATA_LSB = 3;

endpackage

// File: rtl/ocimem_rr_arb.sv
// Two-requester round-robin (Avalon vs JTAG); combinational grant, one register of history.
// History only moves when a contested grant is actually taken, so lone requesters never stall.
module ocimem_rr_arb (
    input  logic clk,
    input  logic reset,
    input  logic req_av_i,
    input  logic req_jt_i,
    input  logic take_i,
    output logic gnt_jt_o
);

    logic last_jt_q;

    assign gnt_jt_o = req_jt_i & (~req_av_i | ~last_jt_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_jt_q <= 1'b0;
        end else if (take_i && req_av_i && req_jt_i) begin
            last_jt_q <= gnt_jt_o;
        end
    end

endmodule

// File: rtl/nios_ocimem_arbiter.sv
// Shares the single-port OCI RAM between latched JTAG commands and the Avalon debug slave.
// Avalon write 1 cycle / read 2 cycles when uncontended; waitrequest stalls the CPU otherwise.
module nios_ocimem_arbiter
    import nios_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun
);

    state_e            state_q, state_d;
    logic              pend_vld_q;
    jop_e              pend_op_q;
    logic [DATA_W-1:0] pend_dat_q;
    logic [ADDR_W-1:0] jtag_addr_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] mon_q;
    logic              mon_rdy_q;
    logic              ovr_q;

    logic jt_cmd, jt_done, pend_busy, av_req, jt_req, gnt_jt, take;

    wire unused_jdo = ^{jdo[JDO_W-1:JDO_DATA_LSB+DATA_W], jdo[JDO_DATA_LSB-1:0]};

    assign jt_cmd    = take_action_ocimem_b | take_no_action_ocimem_a;
    assign jt_done   = (state_q == ST_JT_WR) || (state_q == ST_JT_RD2);
    // Pending frees up on the completion edge, so a pulse landing then is accepted.
    assign pend_busy = pend_vld_q & ~jt_done;
    assign av_req    = avs_read | avs_write;
    assign jt_req    = pend_vld_q | jt_cmd;
    // A JTAG grant on a fresh pulse holds IDLE one cycle while the command latches.
    assign take      = (state_q == ST_IDLE) && (gnt_jt ? pend_vld_q : av_req);

    ocimem_rr_arb u_arb (
        .clk      (clk),
        .reset    (reset),
        .req_av_i (av_req),
        .req_jt_i (jt_req),
        .take_i   (take),
        .gnt_jt_o (gnt_jt)
    );

    always_comb begin
        state_d         = state_q;
        ram_addr        = '0;
        ram_wr          = 1'b0;
        ram_wdata       = '0;
        avs_waitrequest = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    if (gnt_jt) state_d = (pend_op_q == JOP_WR) ? ST_JT_WR : ST_JT_RD1;
                    else        state_d = avs_write ? ST_AV_WR : ST_AV_RD1;
                end
            end
            ST_AV_WR: begin
                ram_addr        = avs_address;
                ram_wr          = 1'b1;
                ram_wdata       = avs_writedata;
                avs_waitrequest = 1'b0;
                state_d         = ST_IDLE;
            end
            ST_AV_RD1: begin
                ram_addr = avs_address;
                state_d  = ST_AV_RD2;
            end
            ST_AV_RD2: begin
                ram_addr        = avs_address;
                avs_waitrequest = 1'b0;
                state_d         = ST_IDLE;
            end
            ST_JT_WR: begin
                ram_addr  = jtag_addr_q;
                ram_wr    = 1'b1;
                ram_wdata = pend_dat_q;
                state_d   = ST_IDLE;
            end
            ST_JT_RD1: begin
                ram_addr = jtag_addr_q;
                state_d  = ST_JT_RD2;
            end
            ST_JT_RD2: begin
                ram_addr = jtag_addr_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // RAM data arrives during AV_RD2 itself; the register keeps it afterwards.
    assign avs_readdata  = (state_q == ST_AV_RD2) ? ram_rdata : rdata_q;
    assign MonDReg       = mon_q;
    assign monitor_ready = mon_rdy_q;
    assign jtag_overrun  = ovr_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            pend_vld_q  <= 1'b0;
            pend_op_q   <= JOP_WR;
            pend_dat_q  <= '0;
            jtag_addr_q <= '0;
            rdata_q     <= '0;
            mon_q       <= '0;
            mon_rdy_q   <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_AV_RD2) rdata_q <= ram_rdata;
            if (state_q == ST_JT_RD2) mon_q   <= ram_rdata;

            if (jt_done) pend_vld_q <= 1'b0;
            if (jt_cmd) begin
                if (pend_busy) begin
                    ovr_q <= 1'b1;
                end else begin
                    pend_vld_q <= 1'b1;
                    pend_op_q  <= take_no_action_ocimem_a ? JOP_RD : JOP_WR;
                    pend_dat_q <= jdo[JDO_DATA_LSB +: DATA_W];
                end
            end

            if (take_action_ocimem_a) begin
                if (pend_busy) ovr_q <= 1'b1;
                else           jtag_addr_q <= jdo[JDO_ADDR_LSB +: ADDR_W];
            end else if (jt_done) begin
                jtag_addr_q <= jtag_addr_q + ADDR_W'(1);
            end

            if (take_action_ocimem_a || jt_cmd) mon_rdy_q <= 1'b0;
            else if (jt_done)                   mon_rdy_q <= 1'b1;
        end
    end

endmodule
